// File: rtl/vmmu_pkg.sv
// Shared constants for the video-memory arbiter: FSM state encoding and default bus widths.
package vmmu_pkg;

  localparam int unsigned AWIDTH_DEF = 19;
  localparam int unsigned DWIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StAccess  = 2'd1;
  localparam state_t StRecover = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: search starts one past the last granted channel.
module rr_arbiter
  import vmmu_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] req_i,
  input  logic           advance_i,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      cand = IW'((32'(last_q) + off) % NCH);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = idx_o;
    end
  end

  // Reset to the top channel so that channel 0 is first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IW'(NCH - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vmmu_arb.sv
// Multi-channel SRAM arbiter: IDLE -> ACCESS (TWAIT cycles) -> RECOVER per transfer.
// Define VMMU_ARB_PRIO_EN to give channel 0 fixed priority over the round-robin pick.
module vmmu_arb
  import vmmu_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned NCH    = 4,
  parameter int unsigned TWAIT  = 2
) (
  input  logic                MemClk,
  input  logic                MemRst,
  input  logic [NCH-1:0]      ReqValid,
  input  logic [NCH-1:0]      ReqWrite,
  input  logic [NCH*AWIDTH-1:0] ReqAddr,
  input  logic [NCH*DWIDTH-1:0] ReqWData,
  output logic [NCH-1:0]      ReqReady,
  output logic [NCH-1:0]      RspValid,
  output logic [DWIDTH-1:0]   RspData,
  output logic [AWIDTH-1:0]   MemAddrPort,
  output logic [DWIDTH-1:0]   MemDataOut,
  input  logic [DWIDTH-1:0]   MemDataIn,
  output logic                MemDataDrive,
  output logic                MemWriteEnable,
  output logic                MemOutputEnable
);

  localparam int unsigned IW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]  LastCnt = 4'(TWAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     chan_q, chan_d;
  logic              write_q, write_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic [IW-1:0]     rr_idx, sel_idx;
  logic              rr_valid, prio_hit, grant, advance;
  logic              sel_write;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_arbiter (
    .clk_i     (MemClk),
    .rst_i     (MemRst),
    .req_i     (ReqValid),
    .advance_i (advance),
    .idx_o     (rr_idx),
    .valid_o   (rr_valid)
  );

`ifdef VMMU_ARB_PRIO_EN
  // Display fetch pre-empts the rotation without disturbing its pointer.
  assign prio_hit = ReqValid[0];
`else
  assign prio_hit = 1'b0;
`endif

  assign grant   = (state_q == StIdle) && rr_valid && !MemRst;
  assign sel_idx = prio_hit ? '0 : rr_idx;
  assign advance = grant && !prio_hit;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(sel_idx) == i) begin
        sel_write = ReqWrite[i];
        sel_addr  = ReqAddr[i*AWIDTH +: AWIDTH];
        sel_wdata = ReqWData[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StAccess;
          cnt_d   = '0;
          chan_d  = sel_idx;
          write_d = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StRecover;
          if (!write_q) begin
            rdata_d = MemDataIn;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge MemClk) begin
    if (MemRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      chan_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ReqReady = '0;
    RspValid = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant && (32'(sel_idx) == i)) begin
        ReqReady[i] = 1'b1;
      end
      if ((state_q == StRecover) && (32'(chan_q) == i)) begin
        RspValid[i] = 1'b1;
      end
    end
  end

  // Bus stays driven through RECOVER on writes to give the SRAM data hold time.
  assign MemWriteEnable  = !((state_q == StAccess) && write_q);
  assign MemOutputEnable = !((state_q == StAccess) && !write_q);
  assign MemDataDrive    = write_q && ((state_q == StAccess) || (state_q == StRecover));
  assign MemDataOut      = wdata_q;
  assign MemAddrPort     = addr_q;
  assign RspData         = rdata_q;

endmodule

// File: tb/tb_vmmu_arb.sv
// Directed bench for vmmu_arb with default parameters (NCH=4, TWAIT=2).
module tb_vmmu_arb;

  logic        MemClk = 1'b0;
  logic        MemRst;
  logic [3:0]  ReqValid, ReqWrite;
  logic [75:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [3:0]  ReqReady, RspValid;
  logic [7:0]  RspData, MemDataOut, MemDataIn;
  logic [18:0] MemAddrPort;
  logic        MemDataDrive, MemWriteEnable, MemOutputEnable;

  int checks   = 0;
  int failures = 0;

  vmmu_arb dut (
    .MemClk          (MemClk),
    .MemRst          (MemRst),
    .ReqValid        (ReqValid),
    .ReqWrite        (ReqWrite),
    .ReqAddr         (ReqAddr),
    .ReqWData        (ReqWData),
    .ReqReady        (ReqReady),
    .RspValid        (RspValid),
    .RspData         (RspData),
    .MemAddrPort     (MemAddrPort),
    .MemDataOut      (MemDataOut),
    .MemDataIn       (MemDataIn),
    .MemDataDrive    (MemDataDrive),
    .MemWriteEnable  (MemWriteEnable),
    .MemOutputEnable (MemOutputEnable)
  );

  always #5 MemClk = ~MemClk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [7:0]  mdin;
    logic [3:0]  ready;
    logic [3:0]  rspv;
    logic [7:0]  rdata;
    logic        we;
    logic        oe;
    logic        drive;
    logic [18:0] addr;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] write,
                              input logic [7:0] mdin, input logic [3:0] ready,
                              input logic [3:0] rspv, input logic [7:0] rdata, input logic we,
                              input logic oe, input logic drive, input logic [18:0] addr,
                              input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.valid = valid; v.write = write; v.mdin = mdin;
    v.ready = ready; v.rspv = rspv; v.rdata = rdata; v.we = we; v.oe = oe;
    v.drive = drive; v.addr = addr; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc(input logic rst, input logic [3:0] v, input logic [3:0] w,
                     input logic [7:0] d);
    @(posedge MemClk);
    #1;
    MemRst    = rst;
    ReqValid  = v;
    ReqWrite  = w;
    MemDataIn = d;
    @(negedge MemClk);
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    chk($sformatf("r%0d.ready", i), 32'(ReqReady), 32'(v.ready));
    chk($sformatf("r%0d.rspv", i), 32'(RspValid), 32'(v.rspv));
    chk($sformatf("r%0d.rdata", i), 32'(RspData), 32'(v.rdata));
    chk($sformatf("r%0d.we", i), 32'(MemWriteEnable), 32'(v.we));
    chk($sformatf("r%0d.oe", i), 32'(MemOutputEnable), 32'(v.oe));
    chk($sformatf("r%0d.drive", i), 32'(MemDataDrive), 32'(v.drive));
    chk($sformatf("r%0d.addr", i), 32'(MemAddrPort), 32'(v.addr));
    chk($sformatf("r%0d.dout", i), 32'(MemDataOut), 32'(v.dout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    MemRst    = 1'b1;
    ReqValid  = '0;
    ReqWrite  = '0;
    MemDataIn = '0;
    ReqAddr   = {19'h7FFFF, 19'h12345, 19'h00010, 19'h00100};
    ReqWData  = {8'hE7, 8'h5A, 8'h3C, 8'h11};

    // rst valid write mdin | ready rspv rdata we oe drive addr dout
    tbl.push_back(mk(1, 4'b0100, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1, 1, 0, 19'h0, 8'h00));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 8'h00, 4'b0100, 4'b0000, 8'h00, 1, 1, 0, 19'h0, 8'h00));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'hA5, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0100, 8'hA5, 1, 1, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hA5, 1, 1, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 8'h00, 4'b0010, 4'b0000, 8'hA5, 1, 1, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hA5, 0, 1, 1, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hA5, 0, 1, 1, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0010, 8'hA5, 1, 1, 1, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hA5, 1, 1, 0, 19'h00010, 8'h3C));
`ifndef VMMU_ARB_PRIO_EN
    // All four channels request continuously after a reset: order 0,1,2,3,0 every 4 cycles.
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hA5, 1, 1, 0, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0001, 4'b0000, 8'h00, 1, 1, 0, 19'h0, 8'h00));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h00100, 8'h11));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h00100, 8'h11));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0001, 8'h00, 1, 1, 0, 19'h00100, 8'h11));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0010, 4'b0000, 8'h00, 1, 1, 0, 19'h00100, 8'h11));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'hFF, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'hC3, 4'b0000, 4'b0000, 8'h00, 1, 0, 0, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0010, 8'hC3, 1, 1, 0, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0100, 4'b0000, 8'hC3, 1, 1, 0, 19'h00010, 8'h3C));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'hC3, 1, 0, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h96, 4'b0000, 4'b0000, 8'hC3, 1, 0, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0100, 8'h96, 1, 1, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b1000, 4'b0000, 8'h96, 1, 1, 0, 19'h12345, 8'h5A));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h96, 1, 0, 0, 19'h7FFFF, 8'hE7));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h69, 4'b0000, 4'b0000, 8'h96, 1, 0, 0, 19'h7FFFF, 8'hE7));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0000, 4'b1000, 8'h69, 1, 1, 0, 19'h7FFFF, 8'hE7));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 8'h00, 4'b0001, 4'b0000, 8'h69, 1, 1, 0, 19'h7FFFF, 8'hE7));
`endif

    cyc(1, 4'b0000, 4'b0000, 8'h00);
    cyc(1, 4'b0000, 4'b0000, 8'h00);
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].valid, tbl[i].write, tbl[i].mdin);
      chk_vec(i, tbl[i]);
    end

`ifdef VMMU_ARB_PRIO_EN
    // ch0 and ch3 held: ch0 wins every slot; ch3 goes first once ch0 drops.
    cyc(1, 4'b0000, 4'b0000, 8'h00);
    for (int t = 0; t <= 12; t++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0000;
      if (t % 4 == 0) exp_rdy = (t <= 8) ? 4'b0001 : 4'b1000;
      cyc(0, (t <= 8) ? 4'b1001 : 4'b1000, 4'b0000, 8'h00);
      chk($sformatf("prio.t%0d.ready", t), 32'(ReqReady), 32'(exp_rdy));
    end
`endif

    // Reset on the second ACCESS cycle of a write aborts it and rewinds the pointer.
    cyc(1, 4'b0000, 4'b0000, 8'h00);
    cyc(0, 4'b0010, 4'b0010, 8'h00);
    chk("abort.grant", 32'(ReqReady), 32'(4'b0010));
    cyc(0, 4'b0000, 4'b0000, 8'h00);
    chk("abort.acc1_we", 32'(MemWriteEnable), 32'(1'b0));
    chk("abort.acc1_drive", 32'(MemDataDrive), 32'(1'b1));
    cyc(1, 4'b0000, 4'b0000, 8'h00);
    chk("abort.acc2_we", 32'(MemWriteEnable), 32'(1'b0));
    cyc(0, 4'b0000, 4'b0000, 8'h00);
    chk("abort.we", 32'(MemWriteEnable), 32'(1'b1));
    chk("abort.oe", 32'(MemOutputEnable), 32'(1'b1));
    chk("abort.drive", 32'(MemDataDrive), 32'(1'b0));
    chk("abort.rspv", 32'(RspValid), 32'(4'b0000));
    cyc(0, 4'b1010, 4'b0000, 8'h00);
    chk("post.rspv", 32'(RspValid), 32'(4'b0000));
    chk("post.grant", 32'(ReqReady), 32'(4'b0010));
    cyc(0, 4'b1000, 4'b0000, 8'h00);
    chk("post.oe", 32'(MemOutputEnable), 32'(1'b0));
    chk("post.addr", 32'(MemAddrPort), 32'(19'h00010));
    cyc(0, 4'b1000, 4'b0000, 8'h5E);
    cyc(0, 4'b1000, 4'b0000, 8'h00);
    chk("post.rspv1", 32'(RspValid), 32'(4'b0010));
    chk("post.rdata", 32'(RspData), 32'(8'h5E));
    chk("post.no_grant_recover", 32'(ReqReady), 32'(4'b0000));
    cyc(0, 4'b1000, 4'b0000, 8'h00);
    chk("post.grant3", 32'(ReqReady), 32'(4'b1000));
    cyc(0, 4'b0000, 4'b0000, 8'h00);
    chk("post.addr3", 32'(MemAddrPort), 32'(19'h7FFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
